// File: rtl/cache_refill_ctrl.sv
// Cache refill controller: miss handler for a 2-way set-associative cache.
// Invalidates the victim line, writes it back to memory when it is valid and dirty,
// refills the missing line word 0 upward (one read outstanding) and commits the tag last,
// then pulses refill_done_o for one cycle.
//
// Ports:
//   clk_i, rst_ni          clock (rising edge), asynchronous active-low reset
//   miss_*                 miss handshake, missing byte address
//   victim_*               victim way, valid/dirty state, tag and line data (word 0 in LSBs)
//   mem_req_*, mem_wdata_o memory request channel (word-aligned byte address)
//   mem_rvalid_i/rdata_i   memory read return
//   fill_*                 data-array word write port
//   tag_we_o/tag_o/...     tag-array write port (dirty is always written as 0)
//   refill_done_o/done_way_o  one-cycle completion pulse and installed way
module cache_refill_ctrl #(
    parameter int unsigned SETS       = 128,
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 32,
    localparam int unsigned INDEX_W    = $clog2(SETS),
    localparam int unsigned WORD_IDX_W = $clog2(LINE_WORDS),
    localparam int unsigned BYTE_W     = $clog2(DATA_W / 8),
    localparam int unsigned OFS_W      = WORD_IDX_W + BYTE_W,
    localparam int unsigned TAG_W      = ADDR_W - INDEX_W - OFS_W
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         miss_valid_i,
    output logic                         miss_ready_o,
    input  logic [ADDR_W-1:0]            miss_addr_i,
    input  logic                         victim_way_i,
    input  logic                         victim_valid_i,
    input  logic                         victim_dirty_i,
    input  logic [TAG_W-1:0]             victim_tag_i,
    input  logic [LINE_WORDS*DATA_W-1:0] victim_line_i,
    output logic                         mem_req_valid_o,
    input  logic                         mem_req_ready_i,
    output logic                         mem_req_we_o,
    output logic [ADDR_W-1:0]            mem_req_addr_o,
    output logic [DATA_W-1:0]            mem_wdata_o,
    input  logic                         mem_rvalid_i,
    input  logic [DATA_W-1:0]            mem_rdata_i,
    output logic                         fill_we_o,
    output logic                         fill_way_o,
    output logic [INDEX_W-1:0]           fill_index_o,
    output logic [WORD_IDX_W-1:0]        fill_word_o,
    output logic [DATA_W-1:0]            fill_data_o,
    output logic                         tag_we_o,
    output logic [TAG_W-1:0]             tag_o,
    output logic                         tag_valid_o,
    output logic                         refill_done_o,
    output logic                         done_way_o
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StInv    = 3'd1;
    localparam logic [2:0] StWb     = 3'd2;
    localparam logic [2:0] StRdReq  = 3'd3;
    localparam logic [2:0] StRdWait = 3'd4;
    localparam logic [2:0] StCommit = 3'd5;

    localparam logic [WORD_IDX_W-1:0] LastBeat = WORD_IDX_W'(LINE_WORDS - 1);

    logic [2:0]                   state_q, state_d;
    logic [WORD_IDX_W-1:0]        beat_q, beat_d;
    logic                         way_q, way_d;
    logic                         wb_q, wb_d;
    logic [INDEX_W-1:0]           index_q, index_d;
    logic [TAG_W-1:0]             tag_q, tag_d;
    logic [TAG_W-1:0]             vtag_q, vtag_d;
    logic [LINE_WORDS*DATA_W-1:0] vline_q, vline_d;

    // Word view of the captured victim line for the write-back data mux.
    logic [DATA_W-1:0] vwords [LINE_WORDS];
    for (genvar i = 0; i < LINE_WORDS; i++) begin : g_vwords
        assign vwords[i] = vline_q[i*DATA_W +: DATA_W];
    end

    // Byte/word offset of the miss address is not needed: the line is always filled from word 0.
    logic unused_ofs;
    assign unused_ofs = ^miss_addr_i[OFS_W-1:0];

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        way_d   = way_q;
        wb_d    = wb_q;
        index_d = index_q;
        tag_d   = tag_q;
        vtag_d  = vtag_q;
        vline_d = vline_q;

        miss_ready_o    = 1'b0;
        mem_req_valid_o = 1'b0;
        mem_req_we_o    = 1'b0;
        mem_req_addr_o  = '0;
        mem_wdata_o     = '0;
        fill_we_o       = 1'b0;
        fill_way_o      = 1'b0;
        fill_index_o    = '0;
        fill_word_o     = '0;
        fill_data_o     = '0;
        tag_we_o        = 1'b0;
        tag_o           = '0;
        tag_valid_o     = 1'b0;
        refill_done_o   = 1'b0;
        done_way_o      = 1'b0;

        case (state_q)
            StIdle: begin
                miss_ready_o = 1'b1;
                if (miss_valid_i) begin
                    index_d = miss_addr_i[OFS_W +: INDEX_W];
                    tag_d   = miss_addr_i[ADDR_W-1 -: TAG_W];
                    way_d   = victim_way_i;
                    wb_d    = victim_valid_i & victim_dirty_i;
                    vtag_d  = victim_tag_i;
                    vline_d = victim_line_i;
                    state_d = StInv;
                end
            end
            StInv: begin
                // Drop the valid bit first so a partially overwritten line never hits.
                tag_we_o     = 1'b1;
                fill_way_o   = way_q;
                fill_index_o = index_q;
                beat_d       = '0;
                state_d      = wb_q ? StWb : StRdReq;
            end
            StWb: begin
                mem_req_valid_o = 1'b1;
                mem_req_we_o    = 1'b1;
                mem_req_addr_o  = {vtag_q, index_q, beat_q, {BYTE_W{1'b0}}};
                mem_wdata_o     = vwords[beat_q];
                if (mem_req_ready_i) begin
                    if (beat_q == LastBeat) begin
                        beat_d  = '0;
                        state_d = StRdReq;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            StRdReq: begin
                mem_req_valid_o = 1'b1;
                mem_req_addr_o  = {tag_q, index_q, beat_q, {BYTE_W{1'b0}}};
                if (mem_req_ready_i) begin
                    state_d = StRdWait;
                end
            end
            StRdWait: begin
                if (mem_rvalid_i) begin
                    fill_we_o    = 1'b1;
                    fill_way_o   = way_q;
                    fill_index_o = index_q;
                    fill_word_o  = beat_q;
                    fill_data_o  = mem_rdata_i;
                    if (beat_q == LastBeat) begin
                        state_d = StCommit;
                    end else begin
                        beat_d  = beat_q + 1'b1;
                        state_d = StRdReq;
                    end
                end
            end
            StCommit: begin
                tag_we_o      = 1'b1;
                tag_o         = tag_q;
                tag_valid_o   = 1'b1;
                fill_way_o    = way_q;
                fill_index_o  = index_q;
                refill_done_o = 1'b1;
                done_way_o    = way_q;
                state_d       = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            beat_q  <= '0;
            way_q   <= 1'b0;
            wb_q    <= 1'b0;
            index_q <= '0;
            tag_q   <= '0;
            vtag_q  <= '0;
            vline_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            way_q   <= way_d;
            wb_q    <= wb_d;
            index_q <= index_d;
            tag_q   <= tag_d;
            vtag_q  <= vtag_d;
            vline_q <= vline_d;
        end
    end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Self-checking bench for cache_refill_ctrl. Each directed miss pushes its expected
// memory requests, fill writes, tag writes, done pulse and latency into queues; a monitor
// sampling on the falling edge pops and compares whenever the DUT presents one of them.
module tb_cache_refill_ctrl;

    localparam int LINE_WORDS = 4;
    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 32;
    localparam int INDEX_W    = 7;
    localparam int WORD_IDX_W = 2;
    localparam int TAG_W      = 21;

    localparam logic [31:0] EvWr   = 32'd0;
    localparam logic [31:0] EvRd   = 32'd1;
    localparam logic [31:0] EvFill = 32'd2;
    localparam logic [31:0] EvTag  = 32'd3;
    localparam logic [31:0] EvDone = 32'd4;

    logic                         clk_i;
    logic                         rst_ni;
    logic                         miss_valid_i;
    logic                         miss_ready_o;
    logic [ADDR_W-1:0]            miss_addr_i;
    logic                         victim_way_i;
    logic                         victim_valid_i;
    logic                         victim_dirty_i;
    logic [TAG_W-1:0]             victim_tag_i;
    logic [LINE_WORDS*DATA_W-1:0] victim_line_i;
    logic                         mem_req_valid_o;
    logic                         mem_req_ready_i;
    logic                         mem_req_we_o;
    logic [ADDR_W-1:0]            mem_req_addr_o;
    logic [DATA_W-1:0]            mem_wdata_o;
    logic                         mem_rvalid_i;
    logic [DATA_W-1:0]            mem_rdata_i;
    logic                         fill_we_o;
    logic                         fill_way_o;
    logic [INDEX_W-1:0]           fill_index_o;
    logic [WORD_IDX_W-1:0]        fill_word_o;
    logic [DATA_W-1:0]            fill_data_o;
    logic                         tag_we_o;
    logic [TAG_W-1:0]             tag_o;
    logic                         tag_valid_o;
    logic                         refill_done_o;
    logic                         done_way_o;

    cache_refill_ctrl #(
        .SETS       (128),
        .LINE_WORDS (LINE_WORDS),
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .miss_valid_i    (miss_valid_i),
        .miss_ready_o    (miss_ready_o),
        .miss_addr_i     (miss_addr_i),
        .victim_way_i    (victim_way_i),
        .victim_valid_i  (victim_valid_i),
        .victim_dirty_i  (victim_dirty_i),
        .victim_tag_i    (victim_tag_i),
        .victim_line_i   (victim_line_i),
        .mem_req_valid_o (mem_req_valid_o),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_req_we_o    (mem_req_we_o),
        .mem_req_addr_o  (mem_req_addr_o),
        .mem_wdata_o     (mem_wdata_o),
        .mem_rvalid_i    (mem_rvalid_i),
        .mem_rdata_i     (mem_rdata_i),
        .fill_we_o       (fill_we_o),
        .fill_way_o      (fill_way_o),
        .fill_index_o    (fill_index_o),
        .fill_word_o     (fill_word_o),
        .fill_data_o     (fill_data_o),
        .tag_we_o        (tag_we_o),
        .tag_o           (tag_o),
        .tag_valid_o     (tag_valid_o),
        .refill_done_o   (refill_done_o),
        .done_way_o      (done_way_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] kind;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
    } ev_t;

    ev_t ev_q[$];
    int  lat_q[$];
    int  acc_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int ncyc     = 0;
    int fill_cnt = 0;
    int done_cnt = 0;
    int last_done_cyc = 0;
    bit bp_mode  = 1'b0;

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic pop_check(input string name, input logic [31:0] kind, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] c);
        ev_t e;
        if (ev_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: unexpected event a=%0h b=%0h c=%0h, expected none (t=%0t)",
                     name, a, b, c, $time);
        end else begin
            e = ev_q.pop_front();
            check(name, {kind, a, b, c}, {e.kind, e.a, e.b, e.c});
        end
    endtask

    task automatic push_ev(input logic [31:0] kind, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] c);
        ev_t e;
        e.kind = kind;
        e.a    = a;
        e.b    = b;
        e.c    = c;
        ev_q.push_back(e);
    endtask

    // Push the expected event sequence of one miss; max_ev >= 0 truncates it (aborted miss).
    task automatic push_miss(input logic way, input logic [6:0] idx, input logic [31:0] rd_base,
                             input logic [20:0] tag, input logic wb, input logic [31:0] wb_base,
                             input logic [127:0] line, input int lat, input int max_ev);
        ev_t seq[$];
        ev_t e;
        logic [31:0] wi;
        wi = {24'd0, way, idx};
        e = '{EvTag, 32'd0, 32'd0, wi};
        seq.push_back(e);
        if (wb) begin
            for (int k = 0; k < LINE_WORDS; k++) begin
                e = '{EvWr, wb_base + 32'(4 * k), line[k*32 +: 32], 32'd0};
                seq.push_back(e);
            end
        end
        for (int k = 0; k < LINE_WORDS; k++) begin
            e = '{EvRd, rd_base + 32'(4 * k), 32'd0, 32'd0};
            seq.push_back(e);
            e = '{EvFill, 32'(k), (rd_base + 32'(4 * k)) ^ 32'h5A5A_0000, wi};
            seq.push_back(e);
        end
        e = '{EvTag, {11'd0, tag}, 32'd1, wi};
        seq.push_back(e);
        e = '{EvDone, {31'd0, way}, 32'd0, 32'd0};
        seq.push_back(e);
        for (int i = 0; i < seq.size(); i++) begin
            if (max_ev < 0 || i < max_ev) push_ev(seq[i].kind, seq[i].a, seq[i].b, seq[i].c);
        end
        if (max_ev < 0) lat_q.push_back(lat);
    endtask

    // Memory model: zero-wait by default, rvalid the cycle after a read is accepted,
    // read data = address ^ 0x5A5A0000. In bp_mode each request sees 3 not-ready cycles.
    initial begin : mem_model
        bit          rd_hs;
        logic [31:0] rd_addr;
        int          stall;
        rd_hs           = 1'b0;
        rd_addr         = '0;
        stall           = 0;
        mem_req_ready_i = 1'b1;
        mem_rvalid_i    = 1'b0;
        mem_rdata_i     = '0;
        forever begin
            @(posedge clk_i);
            #1;
            mem_rvalid_i = rd_hs;
            mem_rdata_i  = rd_hs ? (rd_addr ^ 32'h5A5A_0000) : 32'h0;
            if (bp_mode) begin
                mem_req_ready_i = mem_req_valid_o && (stall >= 3);
                if (mem_req_valid_o && stall < 3) stall++;
            end else begin
                mem_req_ready_i = 1'b1;
            end
            @(negedge clk_i);
            rd_hs   = mem_req_valid_o && mem_req_ready_i && !mem_req_we_o;
            rd_addr = mem_req_addr_o;
            if (mem_req_valid_o && mem_req_ready_i) stall = 0;
        end
    end

    // Monitor / scoreboard.
    initial begin : monitor
        ev_t f;
        int  acc;
        int  lat;
        forever begin
            @(negedge clk_i);
            ncyc++;
            if (!rst_ni) begin
                acc_q.delete();
            end else begin
                if (mem_req_valid_o && mem_req_ready_i) begin
                    pop_check("mem_req", mem_req_we_o ? EvWr : EvRd, mem_req_addr_o,
                              mem_req_we_o ? mem_wdata_o : 32'd0, 32'd0);
                end else if (mem_req_valid_o) begin
                    if (ev_q.size() == 0) begin
                        pop_check("mem_hold", mem_req_we_o ? EvWr : EvRd, mem_req_addr_o,
                                  32'd0, 32'd0);
                    end else begin
                        f = ev_q[0];
                        check("mem_hold",
                              {mem_req_we_o, mem_req_addr_o, mem_req_we_o ? mem_wdata_o : 32'd0},
                              {f.kind == EvWr, f.a, (f.kind == EvWr) ? f.b : 32'd0});
                    end
                end
                if (fill_we_o) begin
                    pop_check("fill", EvFill, 32'(fill_word_o), fill_data_o,
                              {24'd0, fill_way_o, fill_index_o});
                    fill_cnt++;
                end
                if (tag_we_o) begin
                    pop_check("tag_write", EvTag, tag_valid_o ? {11'd0, tag_o} : 32'd0,
                              {31'd0, tag_valid_o}, {24'd0, fill_way_o, fill_index_o});
                end
                if (refill_done_o) begin
                    pop_check("done", EvDone, {31'd0, done_way_o}, 32'd0, 32'd0);
                    if (acc_q.size() == 0 || lat_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL latency: done with no accepted miss pending (t=%0t)", $time);
                    end else begin
                        acc = acc_q.pop_front();
                        lat = lat_q.pop_front();
                        check("latency", 192'(ncyc - acc), 192'(lat));
                    end
                    done_cnt++;
                    last_done_cyc = ncyc;
                end
                if (miss_valid_i && miss_ready_o) acc_q.push_back(ncyc);
            end
        end
    end

    task automatic issue(input logic [31:0] addr, input logic way, input logic vv, input logic vd,
                         input logic [20:0] vtag, input logic [127:0] line);
        miss_addr_i    = addr;
        victim_way_i   = way;
        victim_valid_i = vv;
        victim_dirty_i = vd;
        victim_tag_i   = vtag;
        victim_line_i  = line;
        miss_valid_i   = 1'b1;
        @(posedge clk_i);
        #1;
        miss_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk_i);
            #1;
            if (miss_ready_o && ev_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: timeout, %0d events still pending, expected 0", name, ev_q.size());
            ev_q.delete();
            lat_q.delete();
        end
    endtask

    function automatic logic [191:0] out_vec();
        return 192'({miss_ready_o, mem_req_valid_o, mem_req_we_o, mem_req_addr_o, mem_wdata_o,
                     fill_we_o, fill_way_o, fill_index_o, fill_word_o, fill_data_o, tag_we_o,
                     tag_o, tag_valid_o, refill_done_o, done_way_o});
    endfunction

    localparam logic [191:0] IdleVec = 192'({1'b1, 134'd0});

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [127:0] line_a;
        logic [127:0] line_c;
        logic [127:0] line_b;
        int           f0;
        int           d0;
        bit           hit;
        line_a = {32'h0000_00A3, 32'h0000_00A2, 32'h0000_00A1, 32'h0000_00A0};
        line_c = {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};
        line_b = {32'hB000_0003, 32'hB000_0002, 32'hB000_0001, 32'hB000_0000};

        rst_ni         = 1'b0;
        miss_valid_i   = 1'b0;
        miss_addr_i    = '0;
        victim_way_i   = 1'b0;
        victim_valid_i = 1'b0;
        victim_dirty_i = 1'b0;
        victim_tag_i   = '0;
        victim_line_i  = '0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        #1;
        check("reset_outputs", out_vec(), IdleVec);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Clean miss, invalid victim.
        push_miss(1'b1, 7'h23, 32'h0000_1230, 21'h2, 1'b0, 32'h0, 128'h0, 10, -1);
        issue(32'h0000_1234, 1'b1, 1'b0, 1'b0, 21'h0, 128'h0);
        wait_idle("clean_miss");

        // Dirty victim: write-back of A0..A3 before any read.
        push_miss(1'b0, 7'h23, 32'h0000_1230, 21'h2, 1'b1, 32'h0000_2A30, line_a, 14, -1);
        issue(32'h0000_1234, 1'b0, 1'b1, 1'b1, 21'h5, line_a);
        wait_idle("dirty_miss");

        // Valid but clean victim: no write-back.
        push_miss(1'b1, 7'h23, 32'h0000_1230, 21'h2, 1'b0, 32'h0, 128'h0, 10, -1);
        issue(32'h0000_1234, 1'b1, 1'b1, 1'b0, 21'h5, line_a);
        wait_idle("valid_clean_miss");

        // Backpressure: 3 stall cycles per read beat -> 12 extra cycles.
        bp_mode = 1'b1;
        push_miss(1'b0, 7'h23, 32'h0000_1230, 21'h2, 1'b0, 32'h0, 128'h0, 22, -1);
        issue(32'h0000_1234, 1'b0, 1'b0, 1'b0, 21'h0, 128'h0);
        wait_idle("backpressure_miss");
        bp_mode = 1'b0;

        // Reset in RD_WAIT after two fills: INV, rd0, fill0, rd1, fill1, rd2 then nothing.
        push_miss(1'b1, 7'h67, 32'h0000_5670, 21'hA, 1'b0, 32'h0, 128'h0, 10, 6);
        f0 = fill_cnt;
        d0 = done_cnt;
        issue(32'h0000_5678, 1'b1, 1'b0, 1'b0, 21'h0, 128'h0);
        hit = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            #1;
            if (fill_cnt >= f0 + 2) begin
                hit = 1'b1;
                break;
            end
        end
        check("reset_test_two_fills", 192'(hit), 192'(1));
        @(posedge clk_i);
        #1;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        @(negedge clk_i);
        #1;
        check("mid_op_reset_outputs", out_vec(), IdleVec);
        check("mid_op_reset_consumed", 192'(ev_q.size()), 192'(0));
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        repeat (4) @(posedge clk_i);
        #1;
        check("no_done_after_reset", {miss_ready_o, 32'(done_cnt)}, {1'b1, 32'(d0)});

        // Next miss after reset completes normally (dirty, all-ones victim tag).
        push_miss(1'b0, 7'h6E, 32'hDEAD_BEE0, 21'h1B_D5B7, 1'b1, 32'hFFFF_FEE0, line_c, 14, -1);
        issue(32'hDEAD_BEEF, 1'b0, 1'b1, 1'b1, 21'h1F_FFFF, line_c);
        wait_idle("post_reset_miss");

        // Busy: miss_valid held high with junk inputs; B accepted the cycle after A's done.
        push_miss(1'b1, 7'h04, 32'h0000_0040, 21'h0, 1'b0, 32'h0, 128'h0, 10, -1);
        push_miss(1'b0, 7'h00, 32'h0001_0000, 21'h20, 1'b1, 32'h0000_1800, line_b, 14, -1);
        miss_addr_i    = 32'h0000_0040;
        victim_way_i   = 1'b1;
        victim_valid_i = 1'b0;
        victim_dirty_i = 1'b0;
        victim_tag_i   = '0;
        victim_line_i  = '0;
        miss_valid_i   = 1'b1;
        @(posedge clk_i);
        #1;
        for (int i = 0; i < 50; i++) begin
            if (miss_ready_o) break;
            miss_addr_i    = $urandom;
            victim_way_i   = 1'($urandom);
            victim_valid_i = 1'($urandom);
            victim_dirty_i = 1'($urandom);
            victim_tag_i   = 21'($urandom);
            victim_line_i  = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk_i);
            #1;
        end
        miss_addr_i    = 32'h0001_0008;
        victim_way_i   = 1'b0;
        victim_valid_i = 1'b1;
        victim_dirty_i = 1'b1;
        victim_tag_i   = 21'h3;
        victim_line_i  = line_b;
        @(negedge clk_i);
        #1;
        check("back_to_back_accept", {miss_ready_o, 32'(ncyc - last_done_cyc)}, {1'b1, 32'd1});
        @(posedge clk_i);
        #1;
        miss_valid_i = 1'b0;
        wait_idle("back_to_back_miss");

        check("queues_drained", {32'(ev_q.size()), 32'(lat_q.size()), 32'(acc_q.size())}, 192'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_refill_ctrl.md
Name: cache_refill_ctrl

Overview:
Miss handler for the 2-way set-associative cache. It consumes the victim way chosen by the replacement policy. If the victim is valid and dirty, it writes the victim line back to memory, then fetches the missing line word by word and writes it into the chosen way. It commits the tag last and then pulses completion so the lookup stage can retry and the replacement state can be updated.

Parameters:
SETS, 128, number of sets; INDEX_W = $clog2(SETS)
LINE_WORDS, 4, words per line (power of 2); WORD_IDX_W = $clog2(LINE_WORDS)
DATA_W, 32, word width in bits (byte offset bits OFS_W = WORD_IDX_W + $clog2(DATA_W/8))
ADDR_W, 32, byte address width; TAG_W = ADDR_W - INDEX_W - OFS_W (21 at defaults)

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
miss_valid_i  in  1  miss request from lookup stage
miss_ready_o  out  1  controller idle, accepts a miss
miss_addr_i  in  ADDR_W  missing byte address
victim_way_i  in  1  way to evict (from replacement policy)
victim_valid_i  in  1  victim line valid
victim_dirty_i  in  1  victim line dirty
victim_tag_i  in  TAG_W  victim line tag
victim_line_i  in  LINE_WORDS*DATA_W  victim line data, word 0 in LSBs
mem_req_valid_o  out  1  memory request valid
mem_req_ready_i  in  1  memory accepts request
mem_req_we_o  out  1  1 = write, 0 = read
mem_req_addr_o  out  ADDR_W  word-aligned byte address
mem_wdata_o  out  DATA_W  write data
mem_rvalid_i  in  1  read data valid
mem_rdata_i  in  DATA_W  read data
fill_we_o  out  1  data-array word write strobe
fill_way_o  out  1  target way (data and tag)
fill_index_o  out  INDEX_W  target set
fill_word_o  out  WORD_IDX_W  target word in line
fill_data_o  out  DATA_W  word to write
tag_we_o  out  1  tag-array write strobe
tag_o  out  TAG_W  tag to write
tag_valid_o  out  1  valid bit to write (dirty is always written 0)
refill_done_o  out  1  one-cycle pulse, line installed
done_way_o  out  1  way installed, valid with refill_done_o

Behaviour:
- FSM states: IDLE, INV, WB, RD_REQ, RD_WAIT, COMMIT. Reset (asynchronous) forces IDLE, beat counter 0, and all captured registers 0.
- Outputs are combinational from state and registers. In IDLE all outputs are 0 except miss_ready_o = 1, which also holds during reset.
- Accept: on miss_valid_i && miss_ready_o, register addr, way, wb_needed = victim_valid_i & victim_dirty_i, victim_tag_i, victim_line_i; go to INV. Inputs are ignored outside IDLE.
- INV (1 cycle): tag_we_o=1, tag_valid_o=0, fill_way_o/fill_index_o = captured. This invalidates the line before any overwrite. Next state is WB if wb_needed, else RD_REQ; beat counter = 0.
- WB: mem_req_valid_o=1, we=1.
  - addr = {victim_tag, index, beat, zeros}; wdata = victim word[beat].
  - Beat advances only on mem_req_ready_i.
  - After beat LINE_WORDS-1 is accepted: counter = 0, go to RD_REQ.
  - Address/data are held stable while ready is low.
- RD_REQ: mem_req_valid_o=1, we=0, addr = {miss tag, index, beat, zeros}. On ready, go to RD_WAIT. Exactly one read is outstanding.
- RD_WAIT: mem_req_valid_o=0. On mem_rvalid_i, in the same cycle: fill_we_o=1, fill_word_o=beat, fill_data_o=mem_rdata_i.
  - If beat is LINE_WORDS-1, go to COMMIT.
  - Otherwise beat+1 and go to RD_REQ.
- mem_rvalid_i outside RD_WAIT is ignored.
- COMMIT (1 cycle): tag_we_o=1, tag_o = miss tag, tag_valid_o=1, refill_done_o=1, done_way_o = captured way; go to IDLE. miss_ready_o returns the next cycle.
- Miss-to-done latency with zero-wait memory (ready=1, rvalid the cycle after accept):
  - clean: 2 + 2*LINE_WORDS cycles
  - dirty: 2 + 3*LINE_WORDS cycles
  - 10 and 14 cycles at defaults.
- Fill order is word 0 upward, regardless of the miss offset.
- fill_way_o/fill_index_o are valid whenever fill_we_o or tag_we_o is asserted.
- Reset mid-operation: immediate IDLE. No COMMIT occurs, so the line stays invalid (already invalidated in INV) and no done pulse is emitted.

Test Plan:
- Clean miss: miss_addr 0x0000_1234, way 1, victim_valid=0, mem ready=1, rvalid 1 cycle after accept.
  - Expect INV at index 0x23, then reads 0x1230, 0x1234, 0x1238, 0x123C.
  - Expect 4 fill writes for words 0..3, then tag_we with tag 0x2 valid=1, and refill_done with done_way=1 exactly 10 cycles after accept.
- Dirty miss: same address, victim valid=1 dirty=1 tag 0x5, line words A0..A3.
  - Expect writes to 0x2A30..0x2A3C carrying A0..A3 before any read.
  - Expect done at 14 cycles.
- Valid but clean victim (dirty=0): expect no write requests, same sequence as the clean miss.
- Backpressure: mem_req_ready_i low for 3 cycles on each beat; expect address/data held stable, no beat skipped or repeated, and done delayed by exactly 12 cycles (clean).
- Reset asserted in RD_WAIT after 2 fills: expect immediate IDLE, miss_ready_o=1, no tag_we valid=1, no refill_done. The next miss completes normally.
- miss_valid_i held high and toggling victim inputs while busy: expect no second accept until the cycle after refill_done. A back-to-back miss is accepted on that cycle.
